// File: rtl/tqvp_quad_gen_pkg.sv
// Shared constants for the four-channel quadrature generator peripheral.
// Register addresses, forward phase sequence and the period reset value.
package tqvp_quad_gen_pkg;

  localparam int NUM_CH     = 4;
  localparam int PRESCALE_W = 16;

  localparam logic [3:0] ADDR_CH0    = 4'd0;
  localparam logic [3:0] ADDR_CH1    = 4'd1;
  localparam logic [3:0] ADDR_CH2    = 4'd2;
  localparam logic [3:0] ADDR_CH3    = 4'd3;
  localparam logic [3:0] ADDR_PERIOD = 4'd4;
  localparam logic [3:0] ADDR_STATUS = 4'd5;
  localparam logic [3:0] ADDR_CLR    = 4'd6;
  localparam logic [3:0] ADDR_MODE   = 4'd7;

  // Forward (A,B) order; A is bit 1 so A leads B.
  localparam logic [1:0] PH_0 = 2'b00;
  localparam logic [1:0] PH_1 = 2'b10;
  localparam logic [1:0] PH_2 = 2'b11;
  localparam logic [1:0] PH_3 = 2'b01;

  localparam logic [7:0] RESET_PERIOD = 8'd128;

  function automatic logic [1:0] phase_next(input logic [1:0] ph, input logic fwd);
    logic [1:0] nxt;
    nxt = PH_0;
    case (ph)
      PH_0:    nxt = fwd ? PH_1 : PH_3;
      PH_1:    nxt = fwd ? PH_2 : PH_0;
      PH_2:    nxt = fwd ? PH_3 : PH_1;
      default: nxt = fwd ? PH_0 : PH_2;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_gen_channel.sv
// One quadrature output channel: pending step request, position count and phase.
// Step/dir output mode is built only when QUAD_GEN_STEP_DIR_EN is defined.
module quad_gen_channel
  import tqvp_quad_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_strobe,
  input  logic       i_load,
  input  logic [7:0] i_load_data,
  input  logic       i_clear,
  input  logic       i_mode,
  output logic       o_a,
  output logic       o_b,
  output logic [7:0] o_position,
  output logic       o_busy
);

  logic signed [7:0] r_pending;
  logic [7:0]        r_position;
  logic [1:0]        r_phase;
  logic              w_step;
  logic              w_fwd;

  // A register write pre-empts any step due in the same cycle.
  assign w_step = i_strobe && !i_load && (r_pending != 8'sd0);
  assign w_fwd  = !r_pending[7];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending  <= 8'sd0;
      r_position <= 8'd0;
      r_phase    <= PH_0;
    end else begin
      if (i_load)
        r_pending <= $signed(i_load_data);
      else if (w_step)
        r_pending <= w_fwd ? r_pending - 8'sd1 : r_pending + 8'sd1;
      if (i_clear)
        r_position <= 8'd0;
      else if (w_step)
        r_position <= w_fwd ? r_position + 8'd1 : r_position - 8'd1;
      if (w_step)
        r_phase <= phase_next(r_phase, w_fwd);
    end
  end

`ifdef QUAD_GEN_STEP_DIR_EN
  logic r_pulse;
  logic r_dir;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pulse <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      if (i_strobe) r_pulse <= w_step;
      if (w_step)   r_dir   <= w_fwd;
    end
  end

  assign o_a = i_mode ? r_pulse : r_phase[1];
  assign o_b = i_mode ? r_dir   : r_phase[0];
`else
  logic w_unused_mode;
  assign w_unused_mode = i_mode;
  assign o_a = r_phase[1];
  assign o_b = r_phase[0];
`endif

  assign o_position = r_position;
  assign o_busy     = (r_pending != 8'sd0);

endmodule

// File: rtl/tqvp_matt_quad_gen.sv
// TinyQV peripheral emitting four channels of quadrature output at a programmable rate.
// Optional step/dir mode register at address 7 enabled by QUAD_GEN_STEP_DIR_EN.
module tqvp_matt_quad_gen
  import tqvp_quad_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [7:0]            r_period;
  logic [PRESCALE_W-1:0] r_prescaler;
  logic [NUM_CH-1:0]     r_mode;
  logic                  w_strobe;
  logic                  w_period_wr;
  logic [NUM_CH-1:0]     w_a;
  logic [NUM_CH-1:0]     w_b;
  logic [NUM_CH-1:0]     w_busy;
  logic [7:0]            w_pos [NUM_CH];
  logic                  w_unused_ui;

  assign w_unused_ui = ^ui_in;
  assign w_strobe    = (r_prescaler == {r_period, 8'h00});
  assign w_period_wr = data_write && (address == ADDR_PERIOD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_period    <= RESET_PERIOD;
      r_prescaler <= '0;
    end else if (w_period_wr) begin
      r_period    <= data_in;
      r_prescaler <= '0;
    end else if (w_strobe) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + 1'b1;
    end
  end

`ifdef QUAD_GEN_STEP_DIR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_mode <= '0;
    else if (data_write && (address == ADDR_MODE))
      r_mode <= data_in[NUM_CH-1:0];
  end
`else
  assign r_mode = '0;
`endif

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    quad_gen_channel u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_strobe    (w_strobe),
      .i_load      (data_write && (address == ADDR_CH0 + 4'(n))),
      .i_load_data (data_in),
      .i_clear     (data_write && (address == ADDR_CLR) && data_in[n]),
      .i_mode      (r_mode[n]),
      .o_a         (w_a[n]),
      .o_b         (w_b[n]),
      .o_position  (w_pos[n]),
      .o_busy      (w_busy[n])
    );
    assign uo_out[2*n]   = w_a[n];
    assign uo_out[2*n+1] = w_b[n];
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_CH0:    data_out = w_pos[0];
      ADDR_CH1:    data_out = w_pos[1];
      ADDR_CH2:    data_out = w_pos[2];
      ADDR_CH3:    data_out = w_pos[3];
      ADDR_PERIOD: data_out = r_period;
      ADDR_STATUS: data_out = {4'b0, w_busy};
      ADDR_MODE:   data_out = {4'b0, r_mode};
      default:     data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_matt_quad_gen.sv
// Self-checking bench for tqvp_matt_quad_gen (default build, step/dir mode not built).
// Directed scenarios followed by random register traffic, checked against a behavioural model.
module tb_tqvp_matt_quad_gen;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;

  // Behavioural model: integer counts and a phase index into the forward sequence.
  int m_pend [4];
  int m_pos  [4];
  int m_ph   [4];
  int m_period;
  int m_cnt;

  tqvp_matt_quad_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_uo();
    logic [7:0] v;
    v = 8'h00;
    for (int n = 0; n < 4; n++) begin
      // index 0..3 -> (A,B) = 00,10,11,01
      v[2*n]   = (m_ph[n] == 1) || (m_ph[n] == 2);
      v[2*n+1] = (m_ph[n] == 2) || (m_ph[n] == 3);
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_reg(input int a);
    logic [7:0] v;
    v = 8'h00;
    if (a < 4) v = 8'(m_pos[a]);
    else if (a == 4) v = 8'(m_period);
    else if (a == 5)
      for (int n = 0; n < 4; n++) v[n] = (m_pend[n] != 0);
    return v;
  endfunction

  task automatic model_edge();
    bit strobe;
    bit [3:0] loaded;
    bit [3:0] clr;
    int s;
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        m_pend[n] = 0; m_pos[n] = 0; m_ph[n] = 0;
      end
      m_period = 128;
      m_cnt = 0;
      return;
    end
    strobe = (m_cnt == m_period * 256);
    loaded = '0;
    clr = '0;
    if (data_write) begin
      if (address < 4) loaded[address[1:0]] = 1'b1;
      if (address == 6) clr = data_in[3:0];
    end
    for (int n = 0; n < 4; n++) begin
      if (loaded[n]) begin
        m_pend[n] = int'($signed(data_in));
      end else if (strobe && m_pend[n] != 0) begin
        s = (m_pend[n] > 0) ? 1 : -1;
        m_pend[n] -= s;
        m_pos[n] = (m_pos[n] + s) & 255;
        m_ph[n]  = (m_ph[n] + s) & 3;
      end
      if (clr[n]) m_pos[n] = 0;
    end
    if (data_write && address == 4) begin
      m_period = int'(data_in);
      m_cnt = 0;
    end else if (strobe) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic do_cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("uo_out", uo_out, exp_uo());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a;
    data_in = d;
    data_write = 1'b1;
    do_cycle();
    data_write = 1'b0;
  endtask

  task automatic check_regs();
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      chk($sformatf("reg%0d", a), data_out, exp_reg(a));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ui_in = 8'h00;
    address = 4'd0;
    data_write = 1'b0;
    data_in = 8'h00;

    // Reset state
    idle(3);
    rst_n = 1'b1;
    chk("rst_uo", uo_out, 8'h00);
    address = 4'd4; #1; chk("rst_period", data_out, 8'h80);
    address = 4'd5; #1; chk("rst_status", data_out, 8'h00);
    check_regs();

    // period=0, three forward steps on ch0
    wr(4'd4, 8'h00);
    wr(4'd0, 8'h03);
    do_cycle(); chk("ch0_step1", uo_out, 8'h01);
    do_cycle(); chk("ch0_step2", uo_out, 8'h03);
    do_cycle(); chk("ch0_step3", uo_out, 8'h02);
    idle(2);
    address = 4'd0; #1; chk("ch0_pos3", data_out, 8'h03);
    address = 4'd5; #1; chk("ch0_idle", data_out, 8'h00);

    // Two backward steps
    wr(4'd0, 8'hFE);
    do_cycle(); chk("ch0_back1", uo_out, 8'h03);
    do_cycle(); chk("ch0_back2", uo_out, 8'h01);
    address = 4'd0; #1; chk("ch0_pos1", data_out, 8'h01);
    check_regs();

    // period=1: strobes every 257 cycles
    wr(4'd4, 8'h01);
    wr(4'd2, 8'h01);
    idle(300);
    wr(4'd2, 8'h02);
    idle(600);
    address = 4'd2; #1; chk("ch2_pos3", data_out, 8'h03);
    check_regs();

    // Wrap and clear on ch1
    wr(4'd4, 8'h00);
    wr(4'd1, 8'hFF);
    idle(3);
    address = 4'd1; #1; chk("ch1_wrap_ff", data_out, 8'hFF);
    wr(4'd1, 8'h02);
    idle(4);
    address = 4'd1; #1; chk("ch1_wrap_01", data_out, 8'h01);
    wr(4'd6, 8'h02);
    address = 4'd1; #1; chk("ch1_cleared", data_out, 8'h00);
    check_regs();

    // Overwrite, then reset mid-request on ch3
    wr(4'd4, 8'h04);
    wr(4'd3, 8'h0A);
    idle(2 * 1025 + 10);
    wr(4'd3, 8'h00);
    address = 4'd3; #1; chk("ch3_pos2", data_out, 8'h02);
    address = 4'd5; #1; chk("ch3_busy_clr", data_out, 8'h00);
    wr(4'd4, 8'h00);
    wr(4'd3, 8'h32);
    idle(5);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("rst_mid_uo", uo_out, 8'h00);
    check_regs();

    // Random register traffic
    wr(4'd4, 8'h00);
    for (int it = 0; it < 250; it++) begin
      logic [3:0] a;
      logic [7:0] d;
      a = 4'($urandom_range(0, 8));
      d = 8'($urandom);
      if (a == 4'd4) d = 8'($urandom_range(0, 1));
      wr(a, d);
      idle($urandom_range(0, 20));
      check_regs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tqvp_matt_quad_gen.md
Name: tqvp_matt_quad_gen

Overview:
TinyQV peripheral that generates four channels of quadrature (A/B) output. It is the transmit-side counterpart of the quadrature encoder reader. The CPU writes a signed step request per channel. The block emits that many quadrature transitions on uo_out at a programmable rate and keeps an 8-bit position count per channel. Typical uses are driving external encoder inputs or motor drivers, and loopback testing of the encoder peripheral.

Parameters:
NUM_CH, 4, number of channels (fixed at 4 by the pin map)
PRESCALE_W, 16, prescaler counter width
RESET_PERIOD, 128, reset value of the period register

Ports:
clk  input  1  system clock (64 MHz nominal)
rst_n  input  1  reset, synchronous, active-low
ui_in  input  8  input PMOD; unused, ignored
uo_out  output  8  uo_out[2n]=A_n, uo_out[2n+1]=B_n for n=0..3
address  input  4  register address within the peripheral
data_write  input  1  write strobe, one cycle, qualifies data_in
data_in  input  8  write data
data_out  output  8  read data, combinational from address

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - pending_n=0, position_n=0, phase_n=00
  - period=RESET_PERIOD, prescaler=0
  - uo_out=0
  - Reset mid-operation aborts all outstanding steps.
- Register map:
  - 0..3 W: pending_n <= data_in, signed 8-bit, overwrites any outstanding request.
  - 0..3 R: position_n.
  - 4 R/W: period.
  - 5 R: {4'b0, busy[3:0]}, where busy_n = (pending_n != 0).
  - 6 W: data_in[n]=1 clears position_n to 0; phase and pending are untouched. Reads 0.
  - 7 and 8..15 R: 0. Writes ignored.
- Prescaler and strobe:
  - strobe = (prescaler == {period, 8'h00}). This is a combinational compare.
  - On strobe the prescaler resets to 0; otherwise it increments.
  - Strobe interval is period*256+1 cycles. period=0 gives a strobe every cycle.
  - Writing period resets the prescaler to 0.
- Step, evaluated at each clk edge where strobe=1:
  - pending>0: phase advances forward, pending-=1, position+=1.
  - pending<0: phase moves backward, pending+=1, position-=1.
  - pending==0: no change.
- Phase encoding:
  - Forward (A,B) sequence is 00 -> 10 -> 11 -> 01 -> 00, so A leads B. The encoder reader counts this as up.
  - Backward is the reverse sequence.
  - Exactly one output bit changes per step, so a glitch-free Gray sequence is guaranteed.
- Outputs are registered directly from phase. Latency is 1 clk from the strobe edge to the output change.
- Arithmetic: position wraps modulo 256 (0xFF+1=0x00, 0x00-1=0xFF). pending never overshoots zero.
- Simultaneous events:
  - A write to channel n in the same cycle as a strobe: the write wins and channel n does not step that cycle.
  - A position clear (address 6) coinciding with a step: the clear wins, position_n=0, and phase still advances.
- pending=0x80 (-128) is legal and produces 128 backward steps.

Optional Feature:
QUAD_GEN_STEP_DIR_EN.
- Defined:
  - Address 7 R/W holds mode[3:0]. Reset value is 0.
  - mode_n=1 switches channel n to step/dir output:
    - A_n = 1 from a strobe edge that performs a step until the next strobe edge, else 0.
    - B_n = direction of the last step (1=forward). It resets to 0.
  - position and pending behave identically in both modes.
- Undefined: address 7 reads 0, writes are ignored, and all channels are always in quadrature mode.

Decomposition:
- Package tqvp_quad_gen_pkg holds:
  - register address localparams (ADDR_CH0..3, ADDR_PERIOD=4, ADDR_STATUS=5, ADDR_CLR=6, ADDR_MODE=7)
  - the 2-bit phase constants for the forward sequence
  - RESET_PERIOD
- Sub-module quad_gen_channel contains pending, position, phase and the optional mode logic. It takes strobe, load, load_data and clear, and outputs a, b, position and busy.
- The top level instantiates the prescaler and four channels.

Test Plan:
- Reset: after rst_n low, uo_out=0x00, addr4 reads 0x80, addr5 reads 0x00, addr0..3 read 0x00.
- period=0, write ch0=3: outputs (A0,B0) are 10, 11, 01 on three consecutive edges. addr0=0x03 and addr5=0x00 afterwards. No other uo_out bits toggle.
- Then write ch0=0xFE: (A0,B0) goes 11, then 10. addr0=0x01.
- period=1, write ch2=1: the first transition occurs on the first strobe. Subsequent strobes are spaced 257 cycles apart, measured on a second request of 2.
- Wrap and clear: drive ch1 position to 0xFF, then request +2 -> addr1=0x01. Write addr6=0x02 -> addr1=0x00 with phase unchanged.
- Overwrite and reset: period=4, write ch3=10, then write ch3=0 after 2 steps -> busy3 clears and position3=2. Assert rst_n mid-request -> all state returns to reset values.
